// File: rtl/uart_tx_dev_if.sv
// ---------------------------------------------------------------------------
// uart_tx_dev_if
//   Bridge-side bus bundle for the memory-mapped UART transmitter.
//   Signals:
//     Addr  [29:0]  word address (only [1:0] decoded by the device)
//     WE            one-cycle write strobe
//     Din   [31:0]  write data
//     Dout  [31:0]  read data, combinational from Addr[1:0]
//   Modports:
//     master  bus bridge / CPU side (drives Addr, WE, Din)
//     slave   device side (drives Dout)
// ---------------------------------------------------------------------------
interface uart_tx_dev_if;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/uart_tx_dev.sv
// ---------------------------------------------------------------------------
// uart_tx_dev
//   Memory-mapped 8N1 UART transmitter with a small TX FIFO and a level IRQ
//   that signals "FIFO drained and line idle".
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  synchronous active-low reset
//     bus    register bus (slave modport): Addr, WE, Din in; Dout out
//     IRQ    registered level interrupt request
//     tx     registered serial line, idle high
//   Register map (Addr[1:0]): 0 CTRL {IE,EN}, 1 STATUS, 2 DIV, 3 TXDATA.
// ---------------------------------------------------------------------------
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_dev_if.slave  bus,
  output logic          IRQ,
  output logic          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Register file and FIFO bookkeeping
  logic [1:0]    ctrl_q;
  logic [15:0]   div_reg_q;
  logic          ovf_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Serialiser state; div_sh_q is the per-frame shadow of DIV
  state_t        state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bitcnt_q;
  logic [15:0]   baud_q;
  logic [15:0]   div_sh_q;
  logic          tx_q;
  logic          irq_q;

  logic wr_ctrl_s, wr_stat_s, wr_div_s, wr_data_s;
  logic full_s, empty_s, pop_s, push_s, ovf_set_s, bit_end_s;
  logic unused_s;

  assign unused_s = ^{bus.Addr[29:2], bus.Din[31:16]};

  // Address decode, FIFO status and push/pop arbitration
  always_comb begin
    wr_ctrl_s = bus.WE && (bus.Addr[1:0] == 2'd0);
    wr_stat_s = bus.WE && (bus.Addr[1:0] == 2'd1);
    wr_div_s  = bus.WE && (bus.Addr[1:0] == 2'd2);
    wr_data_s = bus.WE && (bus.Addr[1:0] == 2'd3);
    full_s    = (count_q == CW'(FIFO_DEPTH));
    empty_s   = (count_q == {CW{1'b0}});
    pop_s     = (state_q == ST_IDLE) && ctrl_q[0] && !empty_s;
    // A push into a full FIFO still lands when the head is leaving this edge
    push_s    = wr_data_s && (!full_s || pop_s);
    ovf_set_s = wr_data_s && full_s && !pop_s;
    bit_end_s = (baud_q == div_sh_q);
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Read mux
  always_comb begin
    case (bus.Addr[1:0])
      2'd0:    bus.Dout = {30'd0, ctrl_q};
      2'd1:    bus.Dout = {23'd0, ovf_q, 5'(count_q), empty_s, full_s,
                           (state_q != ST_IDLE)};
      2'd2:    bus.Dout = {16'd0, div_reg_q};
      default: bus.Dout = 32'd0;
    endcase
  end

  // Control registers, overflow flag and FIFO pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q    <= 2'd0;
      div_reg_q <= DIV_RESET;
      ovf_q     <= 1'b0;
      rd_ptr_q  <= {PW{1'b0}};
      wr_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
    end else begin
      if (wr_ctrl_s) ctrl_q <= bus.Din[1:0];
      if (wr_div_s)  div_reg_q <= bus.Din[15:0];
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end else if (wr_stat_s && bus.Din[8]) begin
        ovf_q <= 1'b0;
      end
      // Depth is a power of two, so pointers wrap naturally
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= bus.Din[7:0];
  end

  // Bit FSM with baud counter, registered tx and IRQ
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'd0;
      bitcnt_q <= 3'd0;
      baud_q   <= 16'd0;
      div_sh_q <= 16'd0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= ctrl_q[1] & ctrl_q[0] & empty_s & (state_q == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            shift_q  <= mem_q[rd_ptr_q];
            div_sh_q <= div_reg_q;
            bitcnt_q <= 3'd0;
            baud_q   <= 16'd0;
            tx_q     <= 1'b0;
            state_q  <= ST_START;
          end else begin
            tx_q <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            baud_q  <= 16'd0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_q <= 16'd0;
            if (bitcnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              // shift_q[1] becomes shift_q[0] after this edge
              shift_q  <= {1'b0, shift_q[7:1]};
              bitcnt_q <= bitcnt_q + 3'd1;
              tx_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            baud_q  <= 16'd0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx  = tx_q;
  assign IRQ = irq_q;

endmodule
